// File: rtl/dvp_frame_scheduler.sv
// -----------------------------------------------------------------------------
// dvp_frame_scheduler
// Frame-level sequencer for the DVP test-pattern path. Produces line/frame
// timing (active pixels, horizontal blank, active lines, vertical blank), runs
// a requested number of frames or runs continuously, and stops only on a frame
// boundary. The source select is applied only when a frame starts, so the DVP
// output never switches source in the middle of a frame.
//
// Ports:
//   i_clk          pixel clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        start pulse, honoured only while idle
//   i_stop         stop request, takes effect at the end of the current frame
//   i_num_frames   frames to send (0 = continuous), latched on accepted start
//   i_sel_req      requested source (1 = internal pattern, 0 = camera)
//   o_busy         scheduler is running
//   o_de           active pixel
//   o_hblank       busy and not an active pixel
//   o_vblank       vertical blanking lines
//   o_pix_x        pixel position in the line
//   o_line_y       line position in the frame
//   o_frame_start  one-cycle pulse on the first cycle of each frame
//   o_done         one-cycle pulse on the first idle cycle after a run
//   o_frames_sent  frames completed since the last accepted start
//   o_sel          applied source select
// -----------------------------------------------------------------------------
module dvp_frame_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 384,
    parameter int V_ACTIVE = 120,
    parameter int V_BLANK  = 80,
    parameter int CNT_W    = 12,
    parameter int FCNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [FCNT_W-1:0] i_num_frames,
    input  logic              i_sel_req,
    output logic              o_busy,
    output logic              o_de,
    output logic              o_hblank,
    output logic              o_vblank,
    output logic [CNT_W-1:0]  o_pix_x,
    output logic [CNT_W-1:0]  o_line_y,
    output logic              o_frame_start,
    output logic              o_done,
    output logic [FCNT_W-1:0] o_frames_sent,
    output logic              o_sel
);

    localparam logic [CNT_W-1:0]  X_LAST     = CNT_W'(H_ACTIVE + H_BLANK - 1);
    localparam logic [CNT_W-1:0]  Y_LAST     = CNT_W'(V_ACTIVE + V_BLANK - 1);
    localparam logic [CNT_W-1:0]  Y_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ZERO  = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ONE   = FCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_VBLANK = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  x_r, x_s;
    logic [CNT_W-1:0]  y_r, y_s;
    logic [FCNT_W-1:0] frames_r, frames_s, frames_inc_s;
    logic [FCNT_W-1:0] num_r, num_s;
    logic              stop_pend_r, stop_pend_s;
    logic              sel_r, sel_s;
    logic              fs_s, done_s;
    logic              busy_r, de_r, hblank_r, vblank_r, fs_r, done_r;
    logic              busy_s, de_s;

    // Next-state logic: pixel/line counting, frame boundary decisions.
    always_comb begin
        state_s      = state_r;
        x_s          = x_r;
        y_s          = y_r;
        frames_s     = frames_r;
        num_s        = num_r;
        stop_pend_s  = stop_pend_r;
        sel_s        = sel_r;
        fs_s         = 1'b0;
        done_s       = 1'b0;
        frames_inc_s = frames_r + FCNT_ONE;

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s     = ST_ACTIVE;
                    x_s         = CNT_ZERO;
                    y_s         = CNT_ZERO;
                    frames_s    = FCNT_ZERO;
                    num_s       = i_num_frames;
                    sel_s       = i_sel_req;
                    fs_s        = 1'b1;
                    // A stop on the start edge still yields one whole frame.
                    stop_pend_s = i_stop;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE, ST_VBLANK: begin
                stop_pend_s = stop_pend_r | i_stop;
                if (x_r == X_LAST) begin
                    x_s = CNT_ZERO;
                    if (y_r == Y_LAST) begin
                        y_s      = CNT_ZERO;
                        frames_s = frames_inc_s;
                        // A stop arriving on the frame-end edge ends this frame.
                        if (stop_pend_r || i_stop ||
                            ((num_r != FCNT_ZERO) && (frames_inc_s == num_r))) begin
                            state_s     = ST_IDLE;
                            done_s      = 1'b1;
                            stop_pend_s = 1'b0;
                        end else begin
                            state_s = ST_ACTIVE;
                            sel_s   = i_sel_req;
                            fs_s    = 1'b1;
                        end
                    end else begin
                        y_s = y_r + CNT_W'(1);
                        if (y_r == Y_ACT_LAST) begin
                            state_s = ST_VBLANK;
                        end else begin
                            state_s = state_r;
                        end
                    end
                end else begin
                    x_s = x_r + CNT_W'(1);
                end
            end
            default: begin
                state_s     = ST_IDLE;
                x_s         = CNT_ZERO;
                y_s         = CNT_ZERO;
                stop_pend_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
        de_s   = (state_s == ST_ACTIVE) && (x_s < H_ACT_C);
    end

    // State, counters and output flags; flags are decoded from the next state
    // so every output comes straight from a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            x_r         <= CNT_ZERO;
            y_r         <= CNT_ZERO;
            frames_r    <= FCNT_ZERO;
            num_r       <= FCNT_ZERO;
            stop_pend_r <= 1'b0;
            sel_r       <= 1'b0;
            busy_r      <= 1'b0;
            de_r        <= 1'b0;
            hblank_r    <= 1'b0;
            vblank_r    <= 1'b0;
            fs_r        <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            y_r         <= y_s;
            frames_r    <= frames_s;
            num_r       <= num_s;
            stop_pend_r <= stop_pend_s;
            sel_r       <= sel_s;
            busy_r      <= busy_s;
            de_r        <= de_s;
            hblank_r    <= busy_s && !de_s;
            vblank_r    <= (state_s == ST_VBLANK);
            fs_r        <= fs_s;
            done_r      <= done_s;
        end
    end

    assign o_busy        = busy_r;
    assign o_de          = de_r;
    assign o_hblank      = hblank_r;
    assign o_vblank      = vblank_r;
    assign o_pix_x       = x_r;
    assign o_line_y      = y_r;
    assign o_frame_start = fs_r;
    assign o_done        = done_r;
    assign o_frames_sent = frames_r;
    assign o_sel         = sel_r;

endmodule

// File: doc/dvp_frame_scheduler.md
Name: dvp_frame_scheduler

Overview:
Frame-level sequencer for the DVP test-pattern path. Generates programmable line/frame timing (active pixels, horizontal blank, active lines, vertical blank), runs a requested number of frames or runs continuously, and stops cleanly on a frame boundary. Owns the pattern/camera source select and applies changes only between frames, so the downstream DVP output never switches source mid-frame.

Parameters:
H_ACTIVE, 640, active pixels per line
H_BLANK, 384, blank pixel clocks per line
V_ACTIVE, 120, active lines per frame
V_BLANK, 80, blank lines per frame
CNT_W, 12, width of pixel and line counters; must hold max(H_ACTIVE+H_BLANK, V_ACTIVE+V_BLANK)-1
FCNT_W, 16, width of frame count and request

Ports:
i_clk  in  1  pixel clock; all logic on rising edge
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start pulse; honoured only in IDLE
i_stop  in  1  stop request; finish current frame, then stop
i_num_frames  in  FCNT_W  frames to send; 0 = continuous; latched on accepted start
i_sel_req  in  1  requested source (1 = internal pattern, 0 = camera passthrough)
o_busy  out  1  high whenever state != IDLE
o_de  out  1  active pixel: state ACTIVE and o_pix_x < H_ACTIVE
o_hblank  out  1  busy and not o_de
o_vblank  out  1  state VBLANK
o_pix_x  out  CNT_W  pixel position in line, 0..H_ACTIVE+H_BLANK-1
o_line_y  out  CNT_W  line in frame, 0..V_ACTIVE+V_BLANK-1
o_frame_start  out  1  one-cycle pulse on first cycle of each frame (x=0,y=0)
o_done  out  1  one-cycle pulse on the cycle the block returns to IDLE
o_frames_sent  out  FCNT_W  frames completed since last accepted start
o_sel  out  1  applied source select

Behaviour:
- Reset (async, i_rst=1): state IDLE; x, y, frame counter, stop_pending, o_sel, latched count = 0. Every output is 0 while reset is asserted and on the first cycle after release. Reset mid-frame aborts immediately; no o_done.
- All outputs are decoded from registered state only; no combinational path from any input to any output.
- L = H_ACTIVE+H_BLANK, F = L*(V_ACTIVE+V_BLANK) clocks per frame.
- States: IDLE, ACTIVE (y < V_ACTIVE), VBLANK (y >= V_ACTIVE).
- IDLE: i_start=1 at edge N -> at N+1 state ACTIVE, x=0, y=0, o_frame_start=1, o_frames_sent=0, i_num_frames latched, o_sel <= i_sel_req.
- x increments each cycle; at x=L-1, x wraps to 0 and y increments; at y=V_ACTIVE-1 with x wrap -> VBLANK.
- Frame end = cycle with x=L-1, y=V_ACTIVE+V_BLANK-1. At that edge: frames counter +1 (mod 2^FCNT_W). Then:
  - stop_pending, or latched count != 0 and incremented count == latched count -> IDLE; o_done=1 on the first IDLE cycle; x, y -> 0; stop_pending cleared.
  - otherwise -> ACTIVE, x=y=0, o_frame_start=1, o_sel <= i_sel_req sampled at that edge.
- o_sel changes only on an accepted start or at a frame boundary; i_sel_req toggles mid-frame are ignored until the next frame start.
- i_stop while busy sets stop_pending (sticky until IDLE). i_stop on the frame-end edge counts for that frame (stops there). i_stop in IDLE alone: ignored.
- i_start while busy: ignored; no restart, no relatch.
- i_start and i_stop on the same IDLE edge: start accepted and stop_pending set -> exactly one frame.
- i_start on the edge where o_done is high: accepted; a new frame begins the next cycle.
- Continuous mode (count 0): runs until i_stop; o_frames_sent wraps silently.

Test Plan:
(Bench params: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1 -> L=6, F=24.)
- Assert i_rst mid-run, then release -> all outputs 0 immediately while asserted and on the first cycle after release; no o_done.
- i_num_frames=2, pulse i_start at edge 0 -> o_frame_start at cycles 1 and 25; o_de high 12 cycles per frame (x 0..3, y 0..2); o_vblank cycles 19-24 and 43-48; o_done at cycle 49 with o_frames_sent=2; o_busy low from 49.
- i_num_frames=0, start, i_stop pulse at cycle 30 -> second frame completes; o_done at cycle 49; o_frames_sent=2.
- i_sel_req=1 at start, set to 0 at cycle 10, continuous mode -> o_sel=1 through cycle 24, becomes 0 at cycle 25 together with o_frame_start.
- i_start pulsed again at cycle 5 while busy -> timing unchanged. Separately, i_start and i_stop on the same IDLE edge -> exactly one frame, o_done at cycle 25.
- Async reset at cycle 7 (o_de=1, x=0, y=1) -> o_de, o_busy, counters go 0 without waiting for a clock edge; a later i_start restarts at x=0, y=0.
